conv_array_ctrl: RTL and testbench
==================================

# conv_array_ctrl

Sequencer for the 4x4 sparse systolic convolution array. It latches a weight tile and derives the per-cell sparse flags. It streams input row-vectors into the array under a valid/ready handshake and tracks each vector through the fixed array latency. It reduces the four column outputs of every vector into one saturating accumulator, and returns one result per frame, a frame being the vectors up to and including the one tagged `x_last`. It sits between the input buffers and the array, and replaces ad-hoc free-running cycle counting with an explicit, reset-able schedule.

## Interface
- `N`, 4: array dimension (rows = columns = N).
- `DATA_W`, 8: width of weights and input elements.
- `PSUM_W`, 9: width of each array column output.
- `ACC_W`, 16: width of the result accumulator.
- `ARRAY_LAT`, 4: cycles from `arr_x` driven to the matching `arr_o` being valid. Must be ≥1.

Ports:
- `clk`  in  1: sole clock; all logic is on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `cfg_valid` / `cfg_ready`  in / out  1: weight-load handshake.
- `cfg_weight`  in  N*N*DATA_W: weight tile, cell r*N+c in the lowest slice first.
- `x_valid` / `x_ready`  in / out  1: input-vector handshake.
- `x_data`  in  N*DATA_W: one input row-vector, element 0 in the lowest slice.
- `x_last`  in  1: marks the final vector of a frame.
- `arr_w`  out  N*N*DATA_W: registered weights to the array.
- `arr_flag`  out  N*N: per-cell enable flags to the array.
- `arr_x`  out  N*DATA_W: registered input vector to the array.
- `arr_o`  in  N*PSUM_W: column outputs from the array, unsigned.
- `res_valid` / `res_ready`  out / in  1: result handshake.
- `res_data`  out  ACC_W: frame result, unsigned.
- `busy`  out  1: high in STREAM and DRAIN.

## Operation
- FSM states are IDLE, ARMED, STREAM, DRAIN and RESULT.
- **IDLE**
  - No weights are held; `cfg_ready`=1 and `x_ready`=0.
  - A cfg handshake latches `arr_w` and `arr_flag` and moves to ARMED.
- **ARMED**
  - `cfg_ready`=1 and `x_ready`=1.
  - A new cfg handshake reloads the weights and the FSM stays in ARMED.
  - An x handshake moves to STREAM, or directly to DRAIN if `x_last`=1.
  - If `cfg_valid` and `x_valid` are both high, cfg wins: `x_ready` is forced to 0 in that cycle.
- **STREAM**
  - `cfg_ready`=0 and `x_ready`=1.
  - Each handshake registers `x_data` into `arr_x` and pushes a 1 into the valid delay line.
  - Cycles with no handshake drive `arr_x`=0 and push a 0.
  - A handshake with `x_last`=1 moves to DRAIN.
- **DRAIN**
  - `x_ready`=0; the FSM waits until the delay line is empty.
  - After the final capture it moves to RESULT.
- **RESULT**
  - `res_valid`=1, and `res_data` holds stable until `res_ready`.
  - On the handshake the accumulator clears and the FSM moves to ARMED; weights are retained.
- **Accumulation**
  - When the delay-line tap is 1, `acc += arr_o[0]+arr_o[1]+arr_o[2]+arr_o[3]`.
  - The column sum is computed at PSUM_W+2 bits.
  - The result saturates at 2^ACC_W−1 and never wraps.
- **Reset (any state, including mid-frame)**
  - FSM returns to IDLE.
  - `arr_w`, `arr_flag`, `arr_x`, the accumulator and the delay line clear to 0.
  - Output values under reset: `res_valid`=0, `res_data`=0, `x_ready`=0, `cfg_ready`=1, `busy`=0.

## Timing
- The cfg handshake at edge t makes `arr_w`/`arr_flag` valid after edge t.
- A vector accepted at edge t appears on `arr_x` after edge t.
- Its `arr_o` is captured at edge t+ARRAY_LAT.
- When the last vector is accepted at edge t, `res_valid` rises after edge t+ARRAY_LAT+1.
- Throughput is one vector per cycle; there is no bubble between consecutive vectors.
- The ARMED→STREAM transition costs no cycle.
- Minimum frame turnaround is ARRAY_LAT+2 cycles after `x_last`, including the RESULT handshake cycle.
- All outputs are registered except `x_ready`, `cfg_ready` and `busy`, which are decoded from state.

## Configuration
- The macro is `CONV_ARRAY_CTRL_SPARSE_EN`.
- **Defined:** `arr_flag[i]` = (weight i != 0), registered with `arr_w`. Zero-weight cells are gated off in the array.
- **Undefined:** `arr_flag` is all ones whenever weights are loaded, and all zeros in IDLE/reset. All other behaviour is identical.

## Structure
- Package `conv_ctrl_pkg` holds:
  - the state enum `conv_ctrl_state_t` (IDLE, ARMED, STREAM, DRAIN, RESULT);
  - default constants `CONV_N`, `CONV_DATA_W`, `CONV_PSUM_W`, `CONV_ACC_W` and `CONV_ARRAY_LAT`;
  - the saturating-add function.
- Sub-module `conv_lat_pipe` is the ARRAY_LAT-deep valid shift register.
  - Its outputs are the tap and an empty flag, and it uses asynchronous active-low reset.
- The FSM, the weight/flag registers and the accumulator live in the top module.

## Test plan
The bench array model returns fixed `arr_o` exactly ARRAY_LAT cycles after each accepted vector.
1. **Basic frame.** Load weights all 1. Stream 3 vectors, the last with `x_last`, with `arr_o`={40,30,20,10}. Expect `res_data`=300 and `res_valid` high 5 cycles after the last accept.
2. **Sparse flags.** Load weights with cell 5 = 0 and all others = 3. With the macro, expect `arr_flag`=16'hFFDF. Without it, expect 16'hFFFF.
3. **Saturation.** Stream a 40-vector frame with `arr_o` all 511, giving a true sum of 81760. Expect `res_data`=65535.
4. **Backpressure and gaps.**
   - Insert 2-cycle `x_valid` gaps mid-frame: the result is unchanged.
   - Hold `res_ready` low 5 cycles: `res_data` stays stable and `x_ready`=0 throughout.
   - After the handshake, `acc` reads 0 and the state is ARMED.
5. **Reset mid-frame.** Assert `rst_n`=0 during STREAM with 2 vectors in flight. Expect all outputs at their reset values.
   - After release, `x_ready`=0 until a new cfg.
   - A following 1-vector frame with `arr_o`={1,1,1,1} yields 4.
6. **cfg/x collision in ARMED.** Assert both valids. Expect the cfg to be accepted with `x_ready`=0 that cycle, and the vector accepted next cycle against the new weights.

Source files
------------

// File: rtl/conv_array_ctrl_pkg.sv
// Shared types, default sizes and the saturating adder for the convolution-array sequencer.
package conv_ctrl_pkg;

    localparam int CONV_N         = 4;
    localparam int CONV_DATA_W    = 8;
    localparam int CONV_PSUM_W    = 9;
    localparam int CONV_ACC_W     = 16;
    localparam int CONV_ARRAY_LAT = 4;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        STREAM,
        DRAIN,
        RESULT
    } conv_ctrl_state_t;

    // Unsigned add clamped to 2^w-1; callers keep w at or below 31.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] max_val;
        sum     = {1'b0, a} + {1'b0, b};
        max_val = (33'd1 << w) - 33'd1;
        return (sum > max_val) ? max_val[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/conv_array_ctrl_lat_pipe.sv
// Valid-tracking shift register matching the fixed array latency.
module conv_lat_pipe #(
    parameter int LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    output logic tap_o,
    output logic empty_o
);

    logic [LAT-1:0] line_q;
    logic [LAT-1:0] line_d;

    genvar gi;
    generate
        for (gi = 0; gi < LAT; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign line_d[gi] = push_i;
            end else begin : g_body
                assign line_d[gi] = line_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign tap_o   = line_q[LAT-1];
    assign empty_o = ~|line_q;

endmodule

// File: rtl/conv_array_ctrl.sv
// Sequencer for the NxN sparse systolic convolution array: weight load, vector streaming,
// latency tracking and per-frame saturating reduction. Define CONV_ARRAY_CTRL_SPARSE_EN for per-cell zero-weight flags.
module conv_array_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int N         = CONV_N,
    parameter int DATA_W    = CONV_DATA_W,
    parameter int PSUM_W    = CONV_PSUM_W,
    parameter int ACC_W     = CONV_ACC_W,
    parameter int ARRAY_LAT = CONV_ARRAY_LAT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [N*N*DATA_W-1:0]    cfg_weight,
    input  logic                     x_valid,
    output logic                     x_ready,
    input  logic [N*DATA_W-1:0]      x_data,
    input  logic                     x_last,
    output logic [N*N*DATA_W-1:0]    arr_w,
    output logic [N*N-1:0]           arr_flag,
    output logic [N*DATA_W-1:0]      arr_x,
    input  logic [N*PSUM_W-1:0]      arr_o,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [ACC_W-1:0]         res_data,
    output logic                     busy
);

    localparam int SUM_W = PSUM_W + 2;

    conv_ctrl_state_t state_q, state_d;

    logic [N*N*DATA_W-1:0] w_q, w_d;
    logic [N*N-1:0]        flag_q, flag_d;
    logic [N*N-1:0]        cfg_flags;
    logic [N*DATA_W-1:0]   x_q, x_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic                  res_valid_q, res_valid_d;

    logic cfg_fire;
    logic x_fire;
    logic pipe_tap;
    logic pipe_empty;

    logic [SUM_W-1:0] part_sum [N+1];

    genvar gi;
    generate
`ifdef CONV_ARRAY_CTRL_SPARSE_EN
        for (gi = 0; gi < N*N; gi++) begin : g_flag
            assign cfg_flags[gi] = |cfg_weight[gi*DATA_W +: DATA_W];
        end
`else
        assign cfg_flags = '1;
`endif
        assign part_sum[0] = '0;
        for (gi = 0; gi < N; gi++) begin : g_colsum
            assign part_sum[gi+1] = part_sum[gi] + SUM_W'(arr_o[gi*PSUM_W +: PSUM_W]);
        end
    endgenerate

    assign cfg_fire = cfg_valid & cfg_ready;
    assign x_fire   = x_valid & x_ready;

    conv_lat_pipe #(
        .LAT(ARRAY_LAT)
    ) u_lat_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (x_fire),
        .tap_o  (pipe_tap),
        .empty_o(pipe_empty)
    );

    // A pending cfg in ARMED blocks x_ready so a weight reload always beats a new frame.
    always_comb begin
        state_d   = state_q;
        cfg_ready = 1'b0;
        x_ready   = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) state_d = ARMED;
            end
            ARMED: begin
                cfg_ready = 1'b1;
                x_ready   = ~cfg_valid;
                if (!cfg_valid && x_valid) state_d = x_last ? DRAIN : STREAM;
            end
            STREAM: begin
                x_ready = 1'b1;
                busy    = 1'b1;
                if (x_valid && x_last) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (pipe_empty) state_d = RESULT;
            end
            RESULT: begin
                if (res_ready) state_d = ARMED;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        w_d         = w_q;
        flag_d      = flag_q;
        x_d         = x_fire ? x_data : '0;
        acc_d       = acc_q;
        res_valid_d = (state_d == RESULT);
        if (cfg_fire) begin
            w_d    = cfg_weight;
            flag_d = cfg_flags;
        end
        if (state_q == RESULT && res_ready) begin
            acc_d = '0;
        end else if (pipe_tap) begin
            acc_d = ACC_W'(sat_add(32'(acc_q), 32'(part_sum[N]), ACC_W));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            w_q         <= '0;
            flag_q      <= '0;
            x_q         <= '0;
            acc_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            flag_q      <= flag_d;
            x_q         <= x_d;
            acc_q       <= acc_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign arr_w     = w_q;
    assign arr_flag  = flag_q;
    assign arr_x     = x_q;
    assign res_valid = res_valid_q;
    assign res_data  = acc_q;

endmodule

// File: tb/tb_conv_array_ctrl.sv
// Directed bench for conv_array_ctrl with a fixed-latency array model driving arr_o.
module tb_conv_array_ctrl;

    localparam int L = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [127:0] cfg_weight;
    logic         x_valid;
    logic         x_ready;
    logic [31:0]  x_data;
    logic         x_last;
    logic [127:0] arr_w;
    logic [15:0]  arr_flag;
    logic [31:0]  arr_x;
    logic [35:0]  arr_o;
    logic         res_valid;
    logic         res_ready;
    logic [15:0]  res_data;
    logic         busy;

    logic [35:0]  arr_pat;
    logic [L-1:0] hist;

    int checks = 0;
    int errors = 0;

    conv_array_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_weight(cfg_weight),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .x_data    (x_data),
        .x_last    (x_last),
        .arr_w     (arr_w),
        .arr_flag  (arr_flag),
        .arr_x     (arr_x),
        .arr_o     (arr_o),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Array model: fixed column outputs exactly L cycles after each accepted vector.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist <= '0;
        else        hist <= {hist[L-2:0], x_valid & x_ready};
    end
    assign arr_o = hist[L-1] ? arr_pat : '0;

    task automatic do_cfg(input logic [127:0] w);
        cfg_weight = w;
        cfg_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
        $display("cfg   weight=%h", w);
    endtask

    task automatic send_vec(input logic [31:0] d, input logic last);
        int n;
        n       = 0;
        x_data  = d;
        x_last  = last;
        x_valid = 1'b1;
        #1;
        while (!x_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL x_accept_timeout x_ready=%0b required=1", x_ready);
        end
        @(posedge clk);
        @(negedge clk);
        x_valid = 1'b0;
        x_last  = 1'b0;
        $display("x     data=%h last=%0b", d, last);
    endtask

    task automatic wait_res(output logic ok);
        int n;
        n = 0;
        while (!res_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        ok = res_valid;
    endtask

    task automatic res_hs();
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        $display("res   handshake");
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({res_valid, x_ready, cfg_ready, busy} !== 4'b0010 || res_data !== 16'd0) begin
            errors++;
            $display("FAIL reset_ctrl got rv=%0b xr=%0b cr=%0b busy=%0b rd=%0d required 0 0 1 0 0",
                     res_valid, x_ready, cfg_ready, busy, res_data);
        end
        checks++;
        if (arr_w !== '0 || arr_flag !== 16'd0 || arr_x !== 32'd0) begin
            errors++;
            $display("FAIL reset_arr got w=%h flag=%h x=%h required all 0", arr_w, arr_flag, arr_x);
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_basic();
        logic early;
        early   = 1'b0;
        arr_pat = {9'd40, 9'd30, 9'd20, 9'd10};
        do_cfg({16{8'h01}});
        checks++;
        if (arr_w !== {16{8'h01}} || arr_flag !== 16'hFFFF) begin
            errors++;
            $display("FAIL basic_weights got w=%h flag=%h required w=0101.. flag=ffff", arr_w, arr_flag);
        end
        send_vec(32'h0403_0201, 1'b0);
        checks++;
        if (arr_x !== 32'h0403_0201 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_arr_x got x=%h busy=%0b required x=04030201 busy=1", arr_x, busy);
        end
        send_vec(32'h0807_0605, 1'b0);
        send_vec(32'h0c0b_0a09, 1'b1);
        for (int k = 0; k < 5; k++) begin
            if (res_valid) early = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (early || res_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency got early=%0b rv_at_5=%0b required early=0 rv_at_5=1", early, res_valid);
        end
        checks++;
        if (res_data !== 16'd300) begin
            errors++;
            $display("FAIL basic_result got %0d required 300", res_data);
        end
        res_hs();
    endtask

    task automatic test_sparse();
        logic [127:0] w;
        w = {16{8'h03}};
        w[5*8 +: 8] = 8'h00;
        do_cfg(w);
        checks++;
`ifdef CONV_ARRAY_CTRL_SPARSE_EN
        if (arr_flag !== 16'hFFDF) begin
            errors++;
            $display("FAIL sparse_flag got %h required ffdf", arr_flag);
        end
`else
        if (arr_flag !== 16'hFFFF) begin
            errors++;
            $display("FAIL sparse_flag got %h required ffff", arr_flag);
        end
`endif
        checks++;
        if (arr_w !== w) begin
            errors++;
            $display("FAIL sparse_weights got %h required %h", arr_w, w);
        end
    endtask

    task automatic test_saturation();
        logic ok;
        arr_pat = {4{9'd511}};
        for (int i = 0; i < 40; i++) send_vec(32'(i), (i == 39) ? 1'b1 : 1'b0);
        wait_res(ok);
        checks++;
        if (!ok || res_data !== 16'd65535) begin
            errors++;
            $display("FAIL saturation got rv=%0b data=%0d required rv=1 data=65535", ok, res_data);
        end
        res_hs();
    endtask

    task automatic test_backpressure();
        logic ok;
        logic bad;
        bad     = 1'b0;
        arr_pat = {9'd40, 9'd30, 9'd20, 9'd10};
        send_vec(32'h1111_1111, 1'b0);
        repeat (2) @(negedge clk);
        send_vec(32'h2222_2222, 1'b0);
        checks++;
        if (arr_x !== 32'h2222_2222) begin
            errors++;
            $display("FAIL gap_arr_x got %h required 22222222", arr_x);
        end
        @(negedge clk);
        checks++;
        if (arr_x !== 32'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL gap_bubble got x=%h busy=%0b required x=0 busy=1", arr_x, busy);
        end
        @(negedge clk);
        send_vec(32'h3333_3333, 1'b1);
        wait_res(ok);
        checks++;
        if (!ok || res_data !== 16'd300) begin
            errors++;
            $display("FAIL gap_result got rv=%0b data=%0d required rv=1 data=300", ok, res_data);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_data !== 16'd300 || x_ready !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL res_hold got rv=%0b data=%0d xr=%0b required rv=1 data=300 xr=0",
                     res_valid, res_data, x_ready);
        end
        res_hs();
        checks++;
        if (res_valid !== 1'b0 || res_data !== 16'd0 || cfg_ready !== 1'b1 || x_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_hs got rv=%0b data=%0d cr=%0b xr=%0b busy=%0b required 0 0 1 1 0",
                     res_valid, res_data, cfg_ready, x_ready, busy);
        end
    endtask

    task automatic test_reset_midframe();
        logic ok;
        send_vec(32'hAAAA_AAAA, 1'b0);
        send_vec(32'hBBBB_BBBB, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({res_valid, x_ready, cfg_ready, busy} !== 4'b0010 || res_data !== 16'd0) begin
            errors++;
            $display("FAIL midreset_ctrl got rv=%0b xr=%0b cr=%0b busy=%0b rd=%0d required 0 0 1 0 0",
                     res_valid, x_ready, cfg_ready, busy, res_data);
        end
        checks++;
        if (arr_w !== '0 || arr_flag !== 16'd0 || arr_x !== 32'd0) begin
            errors++;
            $display("FAIL midreset_arr got w=%h flag=%h x=%h required all 0", arr_w, arr_flag, arr_x);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        x_data  = 32'h5555_5555;
        x_last  = 1'b1;
        x_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (x_ready !== 1'b0 || busy !== 1'b0 || arr_x !== 32'd0) begin
            errors++;
            $display("FAIL after_reset_idle got xr=%0b busy=%0b x=%h required 0 0 0", x_ready, busy, arr_x);
        end
        @(negedge clk);
        x_valid = 1'b0;
        x_last  = 1'b0;
        arr_pat = {4{9'd1}};
        do_cfg({16{8'h02}});
        send_vec(32'h0101_0101, 1'b1);
        wait_res(ok);
        checks++;
        if (!ok || res_data !== 16'd4) begin
            errors++;
            $display("FAIL after_reset_frame got rv=%0b data=%0d required rv=1 data=4", ok, res_data);
        end
        res_hs();
    endtask

    task automatic test_collision();
        logic ok;
        cfg_weight = {16{8'h07}};
        cfg_valid  = 1'b1;
        x_data     = 32'hC0DE_0001;
        x_last     = 1'b1;
        x_valid    = 1'b1;
        #1;
        checks++;
        if (x_ready !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL collide_ready got xr=%0b cr=%0b required xr=0 cr=1", x_ready, cfg_ready);
        end
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
        #1;
        checks++;
        if (arr_w !== {16{8'h07}} || arr_x !== 32'd0 || x_ready !== 1'b1) begin
            errors++;
            $display("FAIL collide_cfg got w=%h x=%h xr=%0b required w=0707.. x=0 xr=1", arr_w, arr_x, x_ready);
        end
        @(posedge clk);
        @(negedge clk);
        x_valid = 1'b0;
        x_last  = 1'b0;
        checks++;
        if (arr_x !== 32'hC0DE_0001 || arr_w !== {16{8'h07}} || busy !== 1'b1) begin
            errors++;
            $display("FAIL collide_vec got x=%h w=%h busy=%0b required x=c0de0001 w=0707.. busy=1",
                     arr_x, arr_w, busy);
        end
        wait_res(ok);
        checks++;
        if (!ok || res_data !== 16'd4) begin
            errors++;
            $display("FAIL collide_result got rv=%0b data=%0d required rv=1 data=4", ok, res_data);
        end
        res_hs();
    endtask

    initial begin
        rst_n      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_weight = '0;
        x_valid    = 1'b0;
        x_data     = '0;
        x_last     = 1'b0;
        res_ready  = 1'b0;
        arr_pat    = '0;
        test_reset();
        test_basic();
        test_sparse();
        test_saturation();
        test_backpressure();
        test_reset_midframe();
        test_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
